ro_buffer: RTL

- Reorder buffer directly downstream of the reservation station and load/store buffer.
- Allocates one entry per issued instruction and captures results broadcast on the rss bus and lsb bus.
- Retires entries in program order: commits register writes and store releases.
- On a mispredicted branch at the head, raises the rob-bus flush and redirects fetch.

---
 rtl/ro_buffer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ro_buffer.sv
// Purpose: reorder buffer; allocates IDs in program order, captures rss/lsb results, retires in order.
// Latency: allocation/writeback visible next cycle, queries bypass both buses, commit outputs registered 1 cycle.
// Backpressure: is_ro_buffer_full refuses issue; rdy low freezes all state and outputs.
module ro_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ID_WIDTH = 5,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,

    input  logic                issue_valid,
    input  logic [4:0]          rd_from_issuer,
    input  logic                is_store_from_issuer,
    input  logic                is_branch_from_issuer,
    input  logic [XLEN-1:0]     pred_pc_from_issuer,
    output logic [ID_WIDTH-1:0] id_to_issuer,
    output logic                is_ro_buffer_full,

    input  logic [ID_WIDTH-1:0] dest_from_rss_bus,
    input  logic [XLEN-1:0]     value_from_rss_bus,
    input  logic [XLEN-1:0]     next_pc_from_rss_bus,
    input  logic [ID_WIDTH-1:0] dest_from_lsb_bus,
    input  logic [XLEN-1:0]     value_from_lsb_bus,

    input  logic [ID_WIDTH-1:0] query_j,
    input  logic [ID_WIDTH-1:0] query_k,
    output logic                ready_j,
    output logic                ready_k,
    output logic [XLEN-1:0]     value_j,
    output logic [XLEN-1:0]     value_k,

    output logic [4:0]          rd_to_reg_file,
    output logic [ID_WIDTH-1:0] dest_to_reg_file,
    output logic [XLEN-1:0]     value_to_reg_file,
    output logic [ID_WIDTH-1:0] store_id_to_lsb,
    output logic                reset_to_rob_bus,
    output logic [XLEN-1:0]     target_pc_to_fetcher
);

    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int CNT_W = $clog2(ROB_SIZE + 1);

    // Entry storage; an ID is its slot index plus one so that 0 can mean "none".
    logic [ROB_SIZE-1:0] busy_q;
    logic [ROB_SIZE-1:0] ready_q;
    logic [4:0]          rd_q        [ROB_SIZE];
    logic [XLEN-1:0]     value_q     [ROB_SIZE];
    logic                is_store_q  [ROB_SIZE];
    logic                is_branch_q [ROB_SIZE];
    logic [XLEN-1:0]     pred_pc_q   [ROB_SIZE];
    logic [XLEN-1:0]     actual_pc_q [ROB_SIZE];

    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [ID_WIDTH-1:0] head_id;
    logic                commit_en;
    logic                mispredict;
    logic                alloc_en;
    logic [IDX_W-1:0]    rss_idx;
    logic [IDX_W-1:0]    lsb_idx;
    logic                rss_hit;
    logic                lsb_hit;

    logic [ID_WIDTH-1:0] qry_id  [2];
    logic                qry_rdy [2];
    logic [XLEN-1:0]     qry_val [2];

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(ROB_SIZE - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    assign id_to_issuer      = ID_WIDTH'(tail_q) + ID_WIDTH'(1);
    assign is_ro_buffer_full = (count_q == CNT_W'(ROB_SIZE));
    assign alloc_en          = issue_valid && !is_ro_buffer_full;

    assign head_id    = ID_WIDTH'(head_q) + ID_WIDTH'(1);
    assign commit_en  = busy_q[head_q] && ready_q[head_q];
    assign mispredict = commit_en && is_branch_q[head_q] &&
                        (actual_pc_q[head_q] != pred_pc_q[head_q]);

    // Bus IDs are only honoured when they name a live entry.
    assign rss_idx = IDX_W'(dest_from_rss_bus - ID_WIDTH'(1));
    assign lsb_idx = IDX_W'(dest_from_lsb_bus - ID_WIDTH'(1));
    assign rss_hit = (dest_from_rss_bus != '0) && (dest_from_rss_bus <= ID_WIDTH'(ROB_SIZE)) &&
                     busy_q[rss_idx];
    assign lsb_hit = (dest_from_lsb_bus != '0) && (dest_from_lsb_bus <= ID_WIDTH'(ROB_SIZE)) &&
                     busy_q[lsb_idx];

    assign qry_id[0] = query_j;
    assign qry_id[1] = query_k;
    assign ready_j   = qry_rdy[0];
    assign value_j   = qry_val[0];
    assign ready_k   = qry_rdy[1];
    assign value_k   = qry_val[1];

    // Operand lookup: same-cycle bus results first (rss over lsb), then stored ready values.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            qry_rdy[p] = 1'b0;
            qry_val[p] = '0;
            if (qry_id[p] != '0) begin
                if (dest_from_rss_bus == qry_id[p]) begin
                    qry_rdy[p] = 1'b1;
                    qry_val[p] = value_from_rss_bus;
                end else if (dest_from_lsb_bus == qry_id[p]) begin
                    qry_rdy[p] = 1'b1;
                    qry_val[p] = value_from_lsb_bus;
                end else if (qry_id[p] <= ID_WIDTH'(ROB_SIZE)) begin
                    if (busy_q[IDX_W'(qry_id[p] - ID_WIDTH'(1))] &&
                        ready_q[IDX_W'(qry_id[p] - ID_WIDTH'(1))]) begin
                        qry_rdy[p] = 1'b1;
                        qry_val[p] = value_q[IDX_W'(qry_id[p] - ID_WIDTH'(1))];
                    end
                end
            end
        end
    end

    // Pointer/flag state, entry updates and registered commit pulses; a mispredict discards everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q               <= '0;
            tail_q               <= '0;
            count_q              <= '0;
            busy_q               <= '0;
            ready_q              <= '0;
            rd_to_reg_file       <= '0;
            dest_to_reg_file     <= '0;
            value_to_reg_file    <= '0;
            store_id_to_lsb      <= '0;
            reset_to_rob_bus     <= 1'b0;
            target_pc_to_fetcher <= '0;
        end else if (rdy) begin
            rd_to_reg_file       <= '0;
            dest_to_reg_file     <= '0;
            value_to_reg_file    <= '0;
            store_id_to_lsb      <= '0;
            reset_to_rob_bus     <= 1'b0;
            target_pc_to_fetcher <= '0;

            if (commit_en) begin
                if (is_store_q[head_q]) begin
                    store_id_to_lsb <= head_id;
                end else begin
                    dest_to_reg_file <= head_id;
                    if (rd_q[head_q] != 5'd0) begin
                        rd_to_reg_file    <= rd_q[head_q];
                        value_to_reg_file <= value_q[head_q];
                    end
                end
            end

            if (mispredict) begin
                reset_to_rob_bus     <= 1'b1;
                target_pc_to_fetcher <= actual_pc_q[head_q];
                busy_q               <= '0;
                ready_q              <= '0;
                head_q               <= '0;
                tail_q               <= '0;
                count_q              <= '0;
            end else begin
                if (lsb_hit) begin
                    ready_q[lsb_idx] <= 1'b1;
                    value_q[lsb_idx] <= value_from_lsb_bus;
                end
                if (rss_hit) begin
                    ready_q[rss_idx]     <= 1'b1;
                    value_q[rss_idx]     <= value_from_rss_bus;
                    actual_pc_q[rss_idx] <= next_pc_from_rss_bus;
                end
                if (commit_en) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= wrap_inc(head_q);
                end
                if (alloc_en) begin
                    busy_q[tail_q]      <= 1'b1;
                    ready_q[tail_q]     <= 1'b0;
                    rd_q[tail_q]        <= rd_from_issuer;
                    is_store_q[tail_q]  <= is_store_from_issuer;
                    is_branch_q[tail_q] <= is_branch_from_issuer;
                    pred_pc_q[tail_q]   <= pred_pc_from_issuer;
                    actual_pc_q[tail_q] <= pred_pc_from_issuer;
                    tail_q              <= wrap_inc(tail_q);
                end
                case ({alloc_en, commit_en})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule
